ttfir_decim: RTL and testbench

//  Downstream stage of the FIR filter: integrate-and-dump decimator on the FIR output.
//  - Accumulates DECIM accepted samples, emits their average, clipped to BW_out.
//  - Converts the full-rate filtered stream into a low-rate stream for the 8-bit output pins.
//  - Flags saturation with a sticky bit.

---
 rtl/ttfir_decim.sv | 121 ++++++++++++
 tb/tb_ttfir_decim.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ttfir_decim.sv
// ttfir_decim: integrate-and-dump decimator on the FIR output stream.
// It sums DECIM = 2**LOG2_DECIM accepted samples, divides by DECIM with an
// arithmetic shift, clips the result to BW_out bits, and raises a sticky
// saturation flag whenever clipping occurs.
// Optional build macro: TTFIR_DECIM_ROUND_EN selects round-half-up at the
// dump. When it is undefined, the dump truncates (floor).
module ttfir_decim #(
  parameter int BW_in      = 8,
  parameter int BW_out     = 6,
  parameter int LOG2_DECIM = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        clr,
  input  logic                                        in_valid,
  input  logic signed [BW_in-1:0]                     y_in,
  output logic signed [BW_out-1:0]                    dec_out,
  output logic                                        out_valid,
  output logic                                        sat_flag,
  output logic [(LOG2_DECIM > 0 ? LOG2_DECIM : 1)-1:0] phase
);

  localparam int DECIM = 1 << LOG2_DECIM;
  localparam int AW    = BW_in + LOG2_DECIM;              // frame sum never overflows
  localparam int PW    = (LOG2_DECIM > 0) ? LOG2_DECIM : 1; // phase is stuck at 0 when DECIM=1

  localparam logic signed [AW:0] MAX_Q = (AW+1)'((1 <<< (BW_out - 1)) - 1);
  localparam logic signed [AW:0] MIN_Q = -MAX_Q - (AW+1)'(1);
`ifdef TTFIR_DECIM_ROUND_EN
  localparam logic signed [AW:0] HALF  = (AW+1)'(DECIM / 2); // 0 when DECIM=1
`endif

  logic signed [AW-1:0]     acc_q, acc_d;
  logic [PW-1:0]            phase_q, phase_d;
  logic signed [BW_out-1:0] dec_q, dec_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_q, sat_d;

  logic signed [AW-1:0]     y_ext;
  logic signed [AW-1:0]     s;
  logic signed [AW:0]       s_w;
  logic signed [AW:0]       q_w;
  logic signed [BW_out-1:0] clip_val;
  logic                     clipped;
  logic                     dump;

  // Datapath: frame sum, divide-by-DECIM shift, and clip to the output range.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    clip_val = '0;
    clipped  = 1'b0;
    y_ext    = AW'(y_in);
    s        = acc_q + y_ext;
    s_w      = (AW+1)'(s);   // one guard bit so the rounding add cannot wrap
`ifdef TTFIR_DECIM_ROUND_EN
    q_w      = (s_w + HALF) >>> LOG2_DECIM;
`else
    q_w      = s_w >>> LOG2_DECIM;
`endif
    if (q_w > MAX_Q) begin
      clip_val = BW_out'(MAX_Q);
      clipped  = 1'b1;
    end else if (q_w < MIN_Q) begin
      clip_val = BW_out'(MIN_Q);
      clipped  = 1'b1;
    end else begin
      clip_val = q_w[BW_out-1:0];
    end
  end

  assign dump = (phase_q == PW'(DECIM - 1));

  // Next state: clr has priority, then accepts a sample (accumulate or dump), otherwise holds.
  always_comb begin
    acc_d       = acc_q;
    phase_d     = phase_q;
    dec_d       = dec_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    if (clr) begin
      acc_d   = '0;
      phase_d = '0;
      sat_d   = 1'b0;
    end else if (in_valid) begin
      if (dump) begin
        acc_d       = '0;
        phase_d     = '0;
        dec_d       = clip_val;
        out_valid_d = 1'b1;
        sat_d       = sat_q | clipped;
      end else begin
        acc_d   = s;
        phase_d = phase_q + PW'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset; a reset discards any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      phase_q     <= '0;
      dec_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      dec_q       <= dec_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign dec_out   = dec_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_ttfir_decim.sv
// Testbench for ttfir_decim with default parameters (BW_in=8, BW_out=6, DECIM=4).
// When a frame's last sample is issued, the stimulus pushes the expected
// {dec_out, sat_flag} into a queue. A monitor pops one entry for every
// out_valid strobe and compares it. Directed checks cover the reset state,
// the phase sequence, hold behaviour, clr, and an asynchronous mid-frame reset.
module tb_ttfir_decim;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic signed [7:0] y_in;
  logic signed [5:0] dec_out;
  logic              out_valid;
  logic              sat_flag;
  logic [1:0]        phase;

  typedef struct {
    int dec;
    int sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ttfir_decim #(.BW_in(8), .BW_out(6), .LOG2_DECIM(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .y_in      (y_in),
    .dec_out   (dec_out),
    .out_valid (out_valid),
    .sat_flag  (sat_flag),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every out_valid strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got dec_out=%0d, expected no out_valid", dec_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_dec_out", int'(dec_out), e.dec);
        check("sb_sat_flag", int'(sat_flag), e.sat);
      end
    end
  end

  // Drive one accepted sample; the inputs change 1 time unit after the edge.
  task automatic send(input int v);
    in_valid = 1'b1;
    y_in     = 8'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full frame; the expectation is pushed just before the dumping sample.
  task automatic frame(input int a, input int b, input int c, input int d,
                       input int exp_dec, input int exp_sat);
    exp_t e;
    send(a);
    send(b);
    send(c);
    e.dec = exp_dec;
    e.sat = exp_sat;
    sb.push_back(e);
    send(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; y_in = '0;
    idle(2);
    check("rst_dec_out", int'(dec_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_phase", int'(phase), 0);
    rst = 1'b1;
    idle(1);

    // 1: four samples of 10, with the phase walked through each step
    for (int i = 0; i < 4; i++) begin
      check("t1_phase", int'(phase), i);
      if (i == 3) begin
        e.dec = 10; e.sat = 0;
        sb.push_back(e);
      end
      send(10);
    end
    check("t1_phase_wrap", int'(phase), 0);
    check("t1_out_valid", int'(out_valid), 1);
    idle(1);
    check("t1_out_valid_low", int'(out_valid), 0);
    check("t1_dec_hold", int'(dec_out), 10);

    // 2 and 3: floor versus round-half-up at the dump
`ifdef TTFIR_DECIM_ROUND_EN
    frame(1, 2, 2, 2, 2, 0);
    frame(-1, -1, -1, -2, -1, 0);
`else
    frame(1, 2, 2, 2, 1, 0);
    frame(-1, -1, -1, -2, -2, 0);
`endif
    idle(1);

    // 4: clipping at both ends, the sticky flag, then clr
    frame(100, 100, 100, 100, 31, 1);
    frame(-128, -128, -128, -128, -32, 1);
    idle(1);
    check("t4_sat_sticky", int'(sat_flag), 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("t4_clr_sat", int'(sat_flag), 0);
    check("t4_clr_dec_hold", int'(dec_out), -32);

    // 5: gaps between samples, then a clr that drops a sample mid-frame
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        e.dec = 5; e.sat = 0;
        sb.push_back(e);
      end
      send(5);
      if (i < 3) begin
        check("t5_gap_no_strobe", int'(out_valid), 0);
        idle(2);
        check("t5_gap_phase_hold", int'(phase), i + 1);
      end
    end
    idle(1);
    send(20);
    send(20);
    clr = 1'b1;
    send(20);
    clr = 1'b0;
    check("t5_clr_phase", int'(phase), 0);
    frame(3, 3, 3, 3, 3, 0);
    idle(1);

    // 6: an asynchronous reset mid-frame clears the outputs with no clock edge
    send(30);
    send(30);
    send(30);
    check("t6_phase_mid", int'(phase), 3);
    #1 rst = 1'b0;
    #1;
    check("t6_async_dec", int'(dec_out), 0);
    check("t6_async_phase", int'(phase), 0);
    check("t6_async_sat", int'(sat_flag), 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    frame(7, 7, 7, 7, 7, 0);
    idle(3);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
